spi_cfg_master: RTL and testbench

- SPI master serializing 24-bit configuration words onto a shared MOSI/SCK bus.
- Two chip selects: ADC1 and PLL.
- Sits directly downstream of the ADC/PLL configuration sequencer. Accepts words from two independent request channels, arbitrates between them, and drives the board pins.
- Adds an accept/done handshake so the sequencer can advance on completion rather than on fixed bit counts.

---
 rtl/spi_cfg_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_cfg_master.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master.sv
// SPI mode-0 master: arbitrates ADC/PLL 24-bit config words and shifts them out MSB first.
// Define SPI_READBACK_EN to add MISO capture (miso, rd_data, rd_valid).
module spi_cfg_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_req,
  input  logic [23:0] adc_data,
  output logic        adc_ack,
  input  logic        pll_req,
  input  logic [23:0] pll_data,
  output logic        pll_ack,
  output logic        done,
  output logic        busy,
  output logic        mosi,
  output logic        sck,
  output logic        SpiAdc1CSB_po,
  output logic        SpiPllCSB_po
`ifdef SPI_READBACK_EN
  ,
  input  logic        miso,
  output logic [23:0] rd_data,
  output logic        rd_valid
`endif
);

  localparam int unsigned DW = 24;
  localparam int unsigned TW = 8;
  localparam int unsigned BW = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [DW-1:0]   r_shift, w_shift_nxt;
  logic [TW-1:0]   r_tcnt, w_tcnt_nxt;
  logic [BW-1:0]   r_bcnt, w_bcnt_nxt;
  logic            r_sck, w_sck_nxt;
  logic            r_mosi, w_mosi_nxt;
  logic            r_adc_csb, w_adc_csb_nxt;
  logic            r_pll_csb, w_pll_csb_nxt;
  logic            r_adc_ack, w_adc_ack_nxt;
  logic            r_pll_ack, w_pll_ack_nxt;
  logic            r_done, w_done_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_last_adc, w_last_adc_nxt;

  logic            w_gnt_adc;
  logic            w_gnt_pll;
  logic [DW-1:0]   w_sel_data;

`ifdef SPI_READBACK_EN
  logic [DW-1:0]   r_rx, w_rx_nxt;
  logic [DW-1:0]   r_rd_data, w_rd_data_nxt;
  logic            r_rd_valid, w_rd_valid_nxt;
`endif

  // Round-robin: on a tie, serve whichever channel was not served last.
  assign w_gnt_adc  = adc_req && (!pll_req || !r_last_adc);
  assign w_gnt_pll  = pll_req && !w_gnt_adc;
  assign w_sel_data = w_gnt_adc ? adc_data : pll_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_tcnt_nxt     = r_tcnt;
    w_bcnt_nxt     = r_bcnt;
    w_sck_nxt      = r_sck;
    w_mosi_nxt     = r_mosi;
    w_adc_csb_nxt  = r_adc_csb;
    w_pll_csb_nxt  = r_pll_csb;
    w_adc_ack_nxt  = 1'b0;
    w_pll_ack_nxt  = 1'b0;
    w_done_nxt     = 1'b0;
    w_busy_nxt     = r_busy;
    w_last_adc_nxt = r_last_adc;
`ifdef SPI_READBACK_EN
    w_rx_nxt       = r_rx;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_gnt_adc || w_gnt_pll) begin
          w_state_nxt    = S_SETUP;
          w_shift_nxt    = w_sel_data;
          w_mosi_nxt     = w_sel_data[DW-1];
          w_adc_csb_nxt  = !w_gnt_adc;
          w_pll_csb_nxt  = !w_gnt_pll;
          w_adc_ack_nxt  = w_gnt_adc;
          w_pll_ack_nxt  = w_gnt_pll;
          w_last_adc_nxt = w_gnt_adc;
          w_busy_nxt     = 1'b1;
          w_tcnt_nxt     = '0;
          w_bcnt_nxt     = '0;
          w_sck_nxt      = 1'b0;
        end
      end
      S_SETUP: begin
        if (r_tcnt == TW'(CS_SETUP - 1)) begin
          w_state_nxt = S_SHIFT;
          w_tcnt_nxt  = '0;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      // Each half-period is CLK_DIV cycles; mosi advances only on sck falling.
      S_SHIFT: begin
        if (r_tcnt == TW'(CLK_DIV - 1)) begin
          w_tcnt_nxt = '0;
          if (!r_sck) begin
            w_sck_nxt = 1'b1;
`ifdef SPI_READBACK_EN
            w_rx_nxt  = {r_rx[DW-2:0], miso};
`endif
          end else begin
            w_sck_nxt = 1'b0;
            if (r_bcnt == BW'(DW - 1)) begin
              w_state_nxt = S_HOLD;
            end else begin
              w_bcnt_nxt  = r_bcnt + BW'(1);
              w_shift_nxt = {r_shift[DW-2:0], 1'b0};
              w_mosi_nxt  = r_shift[DW-2];
            end
          end
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      S_HOLD: begin
        if (r_tcnt == TW'(CS_HOLD - 1)) begin
          w_state_nxt   = S_GAP;
          w_tcnt_nxt    = '0;
          w_adc_csb_nxt = 1'b1;
          w_pll_csb_nxt = 1'b1;
          w_mosi_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
`ifdef SPI_READBACK_EN
          w_rd_data_nxt  = r_rx;
          w_rd_valid_nxt = 1'b1;
`endif
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      S_GAP: begin
        if (r_tcnt == TW'(CS_GAP - 1)) begin
          w_state_nxt = S_IDLE;
          w_tcnt_nxt  = '0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_adc_csb_nxt = 1'b1;
        w_pll_csb_nxt = 1'b1;
        w_sck_nxt     = 1'b0;
        w_mosi_nxt    = 1'b0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_tcnt     <= '0;
      r_bcnt     <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_adc_csb  <= 1'b1;
      r_pll_csb  <= 1'b1;
      r_adc_ack  <= 1'b0;
      r_pll_ack  <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_last_adc <= 1'b0;
    end else begin
      r_shift    <= w_shift_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_sck      <= w_sck_nxt;
      r_mosi     <= w_mosi_nxt;
      r_adc_csb  <= w_adc_csb_nxt;
      r_pll_csb  <= w_pll_csb_nxt;
      r_adc_ack  <= w_adc_ack_nxt;
      r_pll_ack  <= w_pll_ack_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
      r_last_adc <= w_last_adc_nxt;
    end
  end

`ifdef SPI_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx       <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rx       <= w_rx_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`endif

  assign adc_ack       = r_adc_ack;
  assign pll_ack       = r_pll_ack;
  assign done          = r_done;
  assign busy          = r_busy;
  assign mosi          = r_mosi;
  assign sck           = r_sck;
  assign SpiAdc1CSB_po = r_adc_csb;
  assign SpiPllCSB_po  = r_pll_csb;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Scoreboard bench for spi_cfg_master: channel drivers, a bus monitor that rebuilds frames, per-scenario checks.
module tb_spi_cfg_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_req = 1'b0;
  logic [23:0] adc_data = '0;
  logic        adc_ack;
  logic        pll_req = 1'b0;
  logic [23:0] pll_data = '0;
  logic        pll_ack;
  logic        done;
  logic        busy;
  logic        mosi;
  logic        sck;
  logic        SpiAdc1CSB_po;
  logic        SpiPllCSB_po;
`ifdef SPI_READBACK_EN
  logic        miso = 1'b0;
  logic [23:0] rd_data;
  logic        rd_valid;
`endif

  spi_cfg_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_req      (adc_req),
    .adc_data     (adc_data),
    .adc_ack      (adc_ack),
    .pll_req      (pll_req),
    .pll_data     (pll_data),
    .pll_ack      (pll_ack),
    .done         (done),
    .busy         (busy),
    .mosi         (mosi),
    .sck          (sck),
    .SpiAdc1CSB_po(SpiAdc1CSB_po),
    .SpiPllCSB_po (SpiPllCSB_po)
`ifdef SPI_READBACK_EN
    ,
    .miso         (miso),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [23:0] word;
  } exp_t;

  typedef struct {
    int          id;
    logic [23:0] word;
    int          len;
    int          first;
    int          period;
    int          nrise;
    bit          done_seen;
    int          gap;
  } frame_t;

  exp_t        exp_q[$];
  frame_t      obs_q[$];
  logic [23:0] adc_q[$];
  logic [23:0] pll_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Requesters: hold req with the head word until ack, then present the next one.
  always @(negedge clk) begin
    if (adc_ack && adc_q.size() > 0) void'(adc_q.pop_front());
    if (pll_ack && pll_q.size() > 0) void'(pll_q.pop_front());
    if (adc_q.size() > 0) begin adc_req = 1'b1; adc_data = adc_q[0]; end
    else adc_req = 1'b0;
    if (pll_q.size() > 0) begin pll_req = 1'b1; pll_data = pll_q[0]; end
    else pll_req = 1'b0;
  end

  int          both_low_cnt = 0, glitch_cnt = 0, pll_low_cnt = 0, adc_low_cnt = 0;
  int          adc_ack_cnt = 0, pll_ack_cnt = 0, done_cnt = 0;
  int          m_len = 0, m_first = -1, m_second = -1, m_nrise = 0, m_id = 0, m_gap = 0;
  int          m_cur_gap = 1000;
  logic [23:0] m_word = '0;
  bit          prev_cs_low = 1'b0, prev_sck = 1'b0, cs_low;
  logic        prev_mosi = 1'b0;
`ifdef SPI_READBACK_EN
  logic [23:0] rd_at_done = '0;
  logic        rdv_at_done = 1'b0;
  int          rdv_stray = 0;
`endif

  // Bus monitor: rebuilds each CS-low window into a frame with timing information.
  always @(negedge clk) begin
    cs_low = !SpiAdc1CSB_po || !SpiPllCSB_po;
    if (!SpiAdc1CSB_po && !SpiPllCSB_po) both_low_cnt++;
    if (!SpiPllCSB_po) pll_low_cnt++;
    if (!SpiAdc1CSB_po) adc_low_cnt++;
    if (adc_ack) adc_ack_cnt++;
    if (pll_ack) pll_ack_cnt++;
    if (done) done_cnt++;
`ifdef SPI_READBACK_EN
    if (done) begin rd_at_done = rd_data; rdv_at_done = rd_valid; end
    if (rd_valid && !done) rdv_stray++;
`endif
    if (cs_low) begin
      if (!prev_cs_low) begin
        m_len = 0; m_nrise = 0; m_word = '0; m_first = -1; m_second = -1;
        m_id = !SpiAdc1CSB_po ? 0 : 1;
        m_gap = m_cur_gap;
      end else if (mosi !== prev_mosi && !(prev_sck && !sck)) begin
        glitch_cnt++;
      end
      if (sck && !prev_sck) begin
        m_word = {m_word[22:0], mosi};
        if (m_nrise == 0) m_first = m_len;
        else if (m_nrise == 1) m_second = m_len;
        m_nrise++;
      end
      m_len++;
    end else begin
      if (prev_cs_low) begin
        obs_q.push_back('{m_id, m_word, m_len, m_first, m_second - m_first, m_nrise, done, m_gap});
        m_cur_gap = 0;
      end
      m_cur_gap++;
    end
    prev_cs_low = cs_low;
    prev_sck    = sck;
    prev_mosi   = mosi;
  end

`ifdef SPI_READBACK_EN
  localparam logic [23:0] MISO_PAT = 24'hA5A5A5;
  int  s_k = 0;
  bit  s_prev_sck = 1'b0;
  // Mode-0 slave: present the next MISO bit after each rising edge.
  always @(negedge clk) begin
    if (SpiAdc1CSB_po && SpiPllCSB_po) s_k = 0;
    else if (sck && !s_prev_sck) s_k++;
    s_prev_sck = sck;
    miso = (s_k < 24) ? MISO_PAT[23 - s_k] : 1'b0;
  end
`endif

  task automatic wait_obs(input int need, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 * need; n++) begin
      if (obs_q.size() >= need) break;
      @(posedge clk);
    end
    if (obs_q.size() >= need) ok = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors += 7;
    if (SpiAdc1CSB_po !== 1'b1) begin miscompares++; $display("FAIL reset_adc_csb got %b want 1", SpiAdc1CSB_po); end
    if (SpiPllCSB_po !== 1'b1) begin miscompares++; $display("FAIL reset_pll_csb got %b want 1", SpiPllCSB_po); end
    if (sck !== 1'b0) begin miscompares++; $display("FAIL reset_sck got %b want 0", sck); end
    if (mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi got %b want 0", mosi); end
    if ({adc_ack, pll_ack} !== 2'b00) begin miscompares++; $display("FAIL reset_acks got %b want 00", {adc_ack, pll_ack}); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_adc_only();
    frame_t f; exp_t e; bit ok; int a0, p0, n;
    a0 = adc_ack_cnt; p0 = pll_low_cnt;
    adc_q.push_back(24'h000503); exp_q.push_back('{0, 24'h000503});
    wait_obs(1, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL adc_only_timeout got %0d frames want 1", obs_q.size()); return; end
    f = obs_q.pop_front(); e = exp_q.pop_front();
    vectors += 7;
    if (f.id !== e.id) begin miscompares++; $display("FAIL adc_only_cs got %0d want %0d", f.id, e.id); end
    if (f.word !== e.word) begin miscompares++; $display("FAIL adc_only_word got %h want %h", f.word, e.word); end
    if (f.len != 196) begin miscompares++; $display("FAIL adc_only_cs_low got %0d want 196", f.len); end
    if (f.first != 6) begin miscompares++; $display("FAIL adc_only_first_rise got %0d want 6", f.first); end
    if (f.period != 8) begin miscompares++; $display("FAIL adc_only_sck_period got %0d want 8", f.period); end
    if (f.nrise != 24) begin miscompares++; $display("FAIL adc_only_rises got %0d want 24", f.nrise); end
    if (f.done_seen !== 1'b1) begin miscompares++; $display("FAIL adc_only_done got %b want 1", f.done_seen); end
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); n++;
      if (!busy) break;
    end
    vectors += 3;
    if (n != 4) begin miscompares++; $display("FAIL adc_only_busy_drop got %0d want 4", n); end
    if (adc_ack_cnt - a0 != 1) begin miscompares++; $display("FAIL adc_only_ack_cycles got %0d want 1", adc_ack_cnt - a0); end
    if (pll_low_cnt != p0) begin miscompares++; $display("FAIL adc_only_pll_csb got %0d low cycles want 0", pll_low_cnt - p0); end
  endtask

  task automatic test_pll_only();
    frame_t f; exp_t e; bit ok; int a0;
    a0 = adc_low_cnt;
    pll_q.push_back(24'h3CA000); exp_q.push_back('{1, 24'h3CA000});
    wait_obs(1, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL pll_only_timeout got %0d frames want 1", obs_q.size()); return; end
    f = obs_q.pop_front(); e = exp_q.pop_front();
    vectors += 7;
    if (f.id !== e.id) begin miscompares++; $display("FAIL pll_only_cs got %0d want %0d", f.id, e.id); end
    if (f.word !== e.word) begin miscompares++; $display("FAIL pll_only_word got %h want %h", f.word, e.word); end
    if (f.len != 196) begin miscompares++; $display("FAIL pll_only_cs_low got %0d want 196", f.len); end
    if (f.first != 6) begin miscompares++; $display("FAIL pll_only_first_rise got %0d want 6", f.first); end
    if (f.period != 8) begin miscompares++; $display("FAIL pll_only_sck_period got %0d want 8", f.period); end
    if (f.done_seen !== 1'b1) begin miscompares++; $display("FAIL pll_only_done got %b want 1", f.done_seen); end
    if (adc_low_cnt != a0) begin miscompares++; $display("FAIL pll_only_adc_csb got %0d low cycles want 0", adc_low_cnt - a0); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    frame_t f; exp_t e; bit ok;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    adc_q.push_back(24'h00003C); pll_q.push_back(24'h3A8C00);
    exp_q.push_back('{0, 24'h00003C}); exp_q.push_back('{1, 24'h3A8C00});
    wait_obs(2, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL simul_timeout got %0d frames want 2", obs_q.size()); return; end
    for (int k = 0; k < 2; k++) begin
      f = obs_q.pop_front(); e = exp_q.pop_front();
      vectors += 4;
      if (f.id !== e.id) begin miscompares++; $display("FAIL simul_order[%0d] got cs %0d want %0d", k, f.id, e.id); end
      if (f.word !== e.word) begin miscompares++; $display("FAIL simul_word[%0d] got %h want %h", k, f.word, e.word); end
      if (f.len != 196) begin miscompares++; $display("FAIL simul_cs_low[%0d] got %0d want 196", k, f.len); end
      if (f.done_seen !== 1'b1) begin miscompares++; $display("FAIL simul_done[%0d] got %b want 1", k, f.done_seen); end
      if (k == 1) begin
        vectors++;
        if (f.gap < 4) begin miscompares++; $display("FAIL simul_gap got %0d want >=4", f.gap); end
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    frame_t f; exp_t e; bit ok; int a0, p0;
    a0 = adc_ack_cnt; p0 = pll_ack_cnt;
    adc_q.push_back(24'hA10001); adc_q.push_back(24'hA20002);
    pll_q.push_back(24'hB10003); pll_q.push_back(24'hB20004);
    exp_q.push_back('{0, 24'hA10001}); exp_q.push_back('{1, 24'hB10003});
    exp_q.push_back('{0, 24'hA20002}); exp_q.push_back('{1, 24'hB20004});
    wait_obs(4, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_timeout got %0d frames want 4", obs_q.size()); return; end
    for (int k = 0; k < 4; k++) begin
      f = obs_q.pop_front(); e = exp_q.pop_front();
      vectors += 3;
      if (f.id !== e.id) begin miscompares++; $display("FAIL b2b_order[%0d] got cs %0d want %0d", k, f.id, e.id); end
      if (f.word !== e.word) begin miscompares++; $display("FAIL b2b_word[%0d] got %h want %h", k, f.word, e.word); end
      if (k > 0 && f.gap != 5) begin miscompares++; $display("FAIL b2b_gap[%0d] got %0d want 5", k, f.gap); end
    end
    repeat (8) @(negedge clk);
    vectors += 2;
    if (adc_ack_cnt - a0 != 2) begin miscompares++; $display("FAIL b2b_adc_acks got %0d want 2", adc_ack_cnt - a0); end
    if (pll_ack_cnt - p0 != 2) begin miscompares++; $display("FAIL b2b_pll_acks got %0d want 2", pll_ack_cnt - p0); end
  endtask

  task automatic test_reset_mid();
    frame_t f; exp_t e; bit ok; int d0, n;
    d0 = done_cnt;
    adc_q.push_back(24'h001719);
    n = 0;
    while (!(prev_cs_low && m_nrise == 10) && n < 400) begin @(posedge clk); n++; end
    vectors++;
    if (n >= 400) begin miscompares++; $display("FAIL rst_mid_timeout got %0d rises want 10", m_nrise); return; end
    #1 rst_n = 1'b0;
    #1;
    vectors += 4;
    if (SpiAdc1CSB_po !== 1'b1) begin miscompares++; $display("FAIL rst_mid_adc_csb got %b want 1", SpiAdc1CSB_po); end
    if (SpiPllCSB_po !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pll_csb got %b want 1", SpiPllCSB_po); end
    if (sck !== 1'b0) begin miscompares++; $display("FAIL rst_mid_sck got %b want 0", sck); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++; $display("FAIL rst_mid_abort_frame got %0d frames want 1", obs_q.size());
    end else begin
      f = obs_q.pop_front();
      vectors += 2;
      if (f.done_seen !== 1'b0) begin miscompares++; $display("FAIL rst_mid_done_in_frame got %b want 0", f.done_seen); end
      if (f.nrise != 10) begin miscompares++; $display("FAIL rst_mid_rises got %0d want 10", f.nrise); end
    end
    vectors++;
    if (done_cnt != d0) begin miscompares++; $display("FAIL rst_mid_done_count got %0d want %0d", done_cnt, d0); end
    @(negedge clk);
    adc_q.push_back(24'h5A0F3C); exp_q.push_back('{0, 24'h5A0F3C});
    wait_obs(1, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rst_mid_recover_timeout got %0d frames want 1", obs_q.size()); return; end
    f = obs_q.pop_front(); e = exp_q.pop_front();
    vectors += 4;
    if (f.id !== e.id) begin miscompares++; $display("FAIL rst_mid_recover_cs got %0d want %0d", f.id, e.id); end
    if (f.word !== e.word) begin miscompares++; $display("FAIL rst_mid_recover_word got %h want %h", f.word, e.word); end
    if (f.len != 196) begin miscompares++; $display("FAIL rst_mid_recover_cs_low got %0d want 196", f.len); end
    if (f.done_seen !== 1'b1) begin miscompares++; $display("FAIL rst_mid_recover_done got %b want 1", f.done_seen); end
    repeat (8) @(negedge clk);
  endtask

`ifdef SPI_READBACK_EN
  task automatic test_readback();
    frame_t f; exp_t e; bit ok;
    adc_q.push_back(24'h0000FF); exp_q.push_back('{0, 24'h0000FF});
    wait_obs(1, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL readback_timeout got %0d frames want 1", obs_q.size()); return; end
    f = obs_q.pop_front(); e = exp_q.pop_front();
    vectors += 4;
    if (f.word !== e.word) begin miscompares++; $display("FAIL readback_word got %h want %h", f.word, e.word); end
    if (rd_at_done !== 24'hA5A5A5) begin miscompares++; $display("FAIL readback_rd_data got %h want a5a5a5", rd_at_done); end
    if (rdv_at_done !== 1'b1) begin miscompares++; $display("FAIL readback_rd_valid got %b want 1", rdv_at_done); end
    if (rdv_stray != 0) begin miscompares++; $display("FAIL readback_stray_valid got %0d want 0", rdv_stray); end
    repeat (8) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_adc_only();
    test_pll_only();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
`ifdef SPI_READBACK_EN
    test_readback();
`endif
    vectors += 2;
    if (both_low_cnt != 0) begin miscompares++; $display("FAIL both_csb_low got %0d cycles want 0", both_low_cnt); end
    if (glitch_cnt != 0) begin miscompares++; $display("FAIL mosi_off_edge got %0d changes want 0", glitch_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
